alu_serial_seq: RTL and testbench
=================================

// Module: alu_serial_seq
// PURPOSE
//  Bit-serial ALU sequencer: drives the 1-bit ALU slice interface (operand bits, carry-in, funct code) one bit per clock.
//  Accepts W-bit operands and a MIPS funct code over valid/ready, collects the slice's sum and carry bits into a W-bit result.
//  Produces dataOut, zero, overflow and illegal flags. It is the datapath's producer and consumer end of the slice interface.
// PARAMETERS
//  W      32   operand/result width; number of RUN cycles per operation
//  CNT_W  5    bit-counter width, = clog2(W)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low; clears all state
//  inValid      in   1   request valid
//  inReady      out  1   sequencer can accept a request (IDLE only)
//  dataA        in   W   operand A
//  dataB        in   W   operand B
//  Signal       in   6   funct code: AND=36 OR=37 ADD=32 SUB=34 SLT=42
//  outValid     out  1   result valid
//  outReady     in   1   consumer accepts result
//  dataOut      out  W   result
//  zero         out  1   dataOut == 0
//  overflow     out  1   signed overflow (ADD/SUB only)
//  illegal      out  1   Signal not one of the five codes
//  sliceA       out  1   operand A bit to slice
//  sliceB       out  1   operand B bit to slice
//  sliceSignal  out  6   funct code to slice
//  sliceCin     out  1   carry into slice
//  sliceOut     in   1   slice result bit (combinational from slice inputs)
//  sliceCout    in   1   slice carry out
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. inReady=1. outValid=0. dataOut=0. Flags=0. Counter=0. Carry reg=0. sliceSignal=0.
//  States: IDLE -> RUN (legal accept) | DONE (illegal accept); RUN -> DONE at cnt==W-1; DONE -> IDLE on outReady.
//  IDLE: inReady=1. On inValid&inReady: latch A, B and Signal; cnt<=0; result<=0; carry<=(Signal==SUB||Signal==SLT).
//  RUN: sliceA=A[cnt], sliceB=B[cnt], sliceCin=carry. sliceSignal=SUB when op is SLT, else the latched op.
//  RUN, each edge: result[cnt]<=sliceOut; carry<=sliceCout; cnt<=cnt+1. The carry into bit W-1 is kept as cinMsb.
//  End of RUN: ADD/SUB overflow=cinMsb^sliceCout at bit W-1. AND/OR/SLT overflow=0.
//  SLT: dataOut={W-1'b0, sumMsb^ovf}, with ovf computed internally. Slice is always run as SUB for SLT.
//  Illegal Signal: no RUN. DONE next edge with dataOut=0, illegal=1, zero=1, overflow=0.
//  Outside RUN: sliceSignal=6'b0; sliceA, sliceB and sliceCin = 0.
//  DONE: outValid=1; dataOut and flags stable until outValid&outReady, then IDLE. inReady=0 in RUN and DONE.
//  Latency: legal op outValid rises W+1 cycles after the accepting edge; illegal op 1 cycle. Throughput: one op per W+2 cycles max.
//  zero is registered with dataOut. Flags are cleared on accept of the next request.
//  cnt never wraps within an op. Reset mid-RUN abandons the op: no partial result, no outValid.
// STRUCTURE
//  Shared include alu_defs.vh: funct constants AND/OR/ADD/SUB/SLT (6'b100100/100101/100000/100010/101010) and state encodings IDLE/RUN/DONE.
//  No sub-module inside: a single FSM plus shift/index datapath. The existing 1-bit ALU slice sits outside.
//  The bench wraps this block and the slice in alu_serial_top.
// TESTING (W=32, bench connects the real 1-bit slice)
//  1 ADD 0x7FFFFFFF+0x00000001 -> dataOut=0x80000000, overflow=1, zero=0; outValid exactly 33 cycles after accept.
//  2 SUB 0x00000005-0x00000005 -> dataOut=0, zero=1, overflow=0; SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
//  3 SLT 0xFFFFFFFF,0x00000001 -> 1; SLT 0x80000000,0x00000001 -> 1 (ovf-corrected); SLT 1,0xFFFFFFFF -> 0; overflow=0 on all three.
//  4 AND 0xF0F0F0F0,0x0FF00FF0 -> 0x00F000F0; OR with the same operands -> 0xFFF0FFF0; overflow=0.
//  5 Signal=6'b000000 -> illegal=1, dataOut=0, outValid 1 cycle after accept; sliceSignal stays 0 throughout.
//  6 outReady low 10 cycles -> outputs stable, inReady=0. Async reset low at cnt=16 -> immediately IDLE, inReady=1, outValid=0.

Source files
------------

// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: MIPS funct codes and FSM states.
package alu_serial_seq_pkg;

  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [5:0] funct);
    logic ok;
    case (funct)
      FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic needs_borrow(input logic [5:0] funct);
    return (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds an external 1-bit ALU slice one bit per clock
// and assembles its sum/carry stream into a W-bit result with zero/overflow/illegal flags.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] dataA,
  input  logic [W-1:0] dataB,
  input  logic [5:0]   Signal,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] dataOut,
  output logic         zero,
  output logic         overflow,
  output logic         illegal,
  output logic         sliceA,
  output logic         sliceB,
  output logic [5:0]   sliceSignal,
  output logic         sliceCin,
  input  logic         sliceOut,
  input  logic         sliceCout
);

  state_t           state_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     result_r;
  logic [5:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;

  logic             last_s;
  logic             ovf_s;
  logic [W-1:0]     final_s;
  logic             final_ovf_s;

  assign last_s = (cnt_r == CNT_W'(W - 1));

  // Final result and overflow, formed from the slice output at the MSB step
  always_comb begin
    // carry_r holds the carry into bit W-1 during the last RUN cycle
    ovf_s           = carry_r ^ sliceCout;
    final_s         = result_r;
    final_s[W-1]    = sliceOut;
    final_ovf_s     = 1'b0;
    case (op_r)
      FUNCT_ADD, FUNCT_SUB: final_ovf_s = ovf_s;
      FUNCT_SLT: begin
        final_s    = '0;
        final_s[0] = sliceOut ^ ovf_s;
      end
      default: final_ovf_s = 1'b0;
    endcase
  end

  // Slice interface: bit-indexed operands during RUN, quiet otherwise
  always_comb begin
    if (state_r == ST_RUN) begin
      sliceA      = a_r[cnt_r];
      sliceB      = b_r[cnt_r];
      sliceCin    = carry_r;
      sliceSignal = (op_r == FUNCT_SLT) ? FUNCT_SUB : op_r;
    end else begin
      sliceA      = 1'b0;
      sliceB      = 1'b0;
      sliceCin    = 1'b0;
      sliceSignal = 6'b000000;
    end
  end

  // Sequencer FSM with operand latches, bit counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      op_r     <= 6'b000000;
      cnt_r    <= '0;
      carry_r  <= 1'b0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      dataOut  <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (inValid && inReady) begin
            a_r      <= dataA;
            b_r      <= dataB;
            op_r     <= Signal;
            cnt_r    <= '0;
            result_r <= '0;
            carry_r  <= needs_borrow(Signal);
            inReady  <= 1'b0;
            dataOut  <= '0;
            overflow <= 1'b0;
            if (is_legal(Signal)) begin
              state_r <= ST_RUN;
              zero    <= 1'b0;
              illegal <= 1'b0;
            end else begin
              state_r  <= ST_DONE;
              outValid <= 1'b1;
              zero     <= 1'b1;
              illegal  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          result_r[cnt_r] <= sliceOut;
          carry_r         <= sliceCout;
          if (last_s) begin
            state_r  <= ST_DONE;
            outValid <= 1'b1;
            dataOut  <= final_s;
            zero     <= (final_s == '0);
            overflow <= final_ovf_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (outReady) begin
            state_r  <= ST_IDLE;
            outValid <= 1'b0;
            inReady  <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          outValid <= 1'b0;
          inReady  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq with a behavioural 1-bit ALU slice attached.
module tb_alu_serial_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic [5:0]   Signal = 6'd0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [W-1:0] dataOut;
  logic         zero;
  logic         overflow;
  logic         illegal;
  logic         sliceA;
  logic         sliceB;
  logic [5:0]   sliceSignal;
  logic         sliceCin;
  logic         sliceOut;
  logic         sliceCout;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] r_data;
  logic         r_zero;
  logic         r_ovf;
  logic         r_ill;
  int           r_lat;
  logic         sig_seen;

  always #5 clk = ~clk;

  alu_serial_seq #(.W(W), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .outValid(outValid), .outReady(outReady),
    .dataOut(dataOut), .zero(zero), .overflow(overflow), .illegal(illegal),
    .sliceA(sliceA), .sliceB(sliceB), .sliceSignal(sliceSignal), .sliceCin(sliceCin),
    .sliceOut(sliceOut), .sliceCout(sliceCout)
  );

  // Reference 1-bit ALU slice
  logic bx;
  always_comb begin
    bx        = (sliceSignal == 6'd34) ? ~sliceB : sliceB;
    sliceOut  = 1'b0;
    sliceCout = 1'b0;
    case (sliceSignal)
      6'd36: sliceOut = sliceA & sliceB;
      6'd37: sliceOut = sliceA | sliceB;
      6'd32, 6'd34: begin
        sliceOut  = sliceA ^ bx ^ sliceCin;
        sliceCout = (sliceA & bx) | (sliceA & sliceCin) | (bx & sliceCin);
      end
      default: sliceOut = 1'b0;
    endcase
  end

  // Issue one request, count edges until outValid, capture outputs, then let the handshake finish
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] s);
    @(negedge clk);
    dataA = a; dataB = b; Signal = s; inValid = 1'b1;
    sig_seen = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    r_lat = 1;
    if (sliceSignal !== 6'd0) sig_seen = 1'b1;
    while (!outValid && r_lat < 100) begin
      @(posedge clk); #1;
      r_lat++;
      if (sliceSignal !== 6'd0) sig_seen = 1'b1;
    end
    if (!outValid) begin
      errors++;
      $display("FAIL timeout op=%0d: outValid never rose", s);
    end
    r_data = dataOut; r_zero = zero; r_ovf = overflow; r_ill = illegal;
    if (outReady) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({inReady, outValid, dataOut, zero, overflow, illegal, sliceSignal} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL reset: inReady=%b outValid=%b dataOut=%h flags=%b%b%b sliceSignal=%0d required 1 0 0 000 0",
               inReady, outValid, dataOut, zero, overflow, illegal, sliceSignal);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add();
    run_op(32'h7FFFFFFF, 32'h00000001, 6'd32);
    checks++;
    if ({r_data, r_ovf, r_zero, r_ill} !== {32'h80000000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_ovf: got %h ovf=%b z=%b ill=%b required 80000000 1 0 0", r_data, r_ovf, r_zero, r_ill);
    end
    checks++;
    if (r_lat !== 33) begin
      errors++;
      $display("FAIL add_latency: got %0d required 33", r_lat);
    end
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL add_return_idle: inReady=%b outValid=%b required 1 0", inReady, outValid);
    end
  endtask

  task automatic test_sub();
    run_op(32'h00000005, 32'h00000005, 6'd34);
    checks++;
    if ({r_data, r_zero, r_ovf} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_zero: got %h z=%b ovf=%b required 0 1 0", r_data, r_zero, r_ovf);
    end
    run_op(32'h80000000, 32'h00000001, 6'd34);
    checks++;
    if ({r_data, r_zero, r_ovf} !== {32'h7FFFFFFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: got %h z=%b ovf=%b required 7fffffff 0 1", r_data, r_zero, r_ovf);
    end
  endtask

  task automatic test_slt();
    logic [W-1:0] av [3] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001};
    logic [W-1:0] bv [3] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF};
    logic [W-1:0] ev [3] = '{32'h1, 32'h1, 32'h0};
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], 6'd42);
      checks++;
      if ({r_data, r_ovf, r_ill} !== {ev[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL slt_%0d: got %h ovf=%b ill=%b required %h 0 0", i, r_data, r_ovf, r_ill, ev[i]);
      end
    end
  endtask

  task automatic test_logic();
    run_op(32'hF0F0F0F0, 32'h0FF00FF0, 6'd36);
    checks++;
    if ({r_data, r_ovf, r_zero} !== {32'h00F000F0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL and: got %h ovf=%b z=%b required 00f000f0 0 0", r_data, r_ovf, r_zero);
    end
    run_op(32'hF0F0F0F0, 32'h0FF00FF0, 6'd37);
    checks++;
    if ({r_data, r_ovf, r_zero} !== {32'hFFF0FFF0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL or: got %h ovf=%b z=%b required fff0fff0 0 0", r_data, r_ovf, r_zero);
    end
  endtask

  task automatic test_illegal();
    run_op(32'h12345678, 32'h9ABCDEF0, 6'd0);
    checks++;
    if ({r_ill, r_data, r_zero, r_ovf} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal_flags: ill=%b data=%h z=%b ovf=%b required 1 0 1 0", r_ill, r_data, r_zero, r_ovf);
    end
    checks++;
    if (r_lat !== 1) begin
      errors++;
      $display("FAIL illegal_latency: got %0d required 1", r_lat);
    end
    checks++;
    if (sig_seen !== 1'b0) begin
      errors++;
      $display("FAIL illegal_slice_signal: sliceSignal went nonzero, required 0");
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'h00000002, 32'h00000002, 6'd32);
    checks++;
    if ({r_data, r_ill, r_zero, r_ovf} !== {32'h4, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_add: got %h ill=%b z=%b ovf=%b required 4 0 0 0", r_data, r_ill, r_zero, r_ovf);
    end
  endtask

  task automatic test_stall();
    outReady = 1'b0;
    run_op(32'h00000003, 32'h00000004, 6'd32);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({outValid, inReady, dataOut, zero, overflow} !== {1'b1, 1'b0, 32'h7, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_%0d: outValid=%b inReady=%b dataOut=%h z=%b ovf=%b required 1 0 7 0 0",
                 i, outValid, inReady, dataOut, zero, overflow);
      end
    end
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: inReady=%b outValid=%b required 1 0", inReady, outValid);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF; Signal = 6'd32; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({inReady, outValid, dataOut, sliceSignal} !== {1'b1, 1'b0, 32'h0, 6'd0}) begin
      errors++;
      $display("FAIL reset_mid_run: inReady=%b outValid=%b dataOut=%h sliceSignal=%0d required 1 0 0 0",
               inReady, outValid, dataOut, sliceSignal);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon: outValid=%b inReady=%b required 0 1", outValid, inReady);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
